// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the multi-cycle memory responder.
package mem_resp_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned BEAT_W      = 2;
    localparam int unsigned BURST_BEATS = 4;

    localparam logic [ADDR_W-1:0] BURST_ALIGN_MASK = 16'hFFF8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [BEAT_W-1:0] beat;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rsp_rec_t;

    // Byte address of the 16-bit word containing a.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_responder_delay_line.sv
// Fixed-depth shift register carrying read responses toward the output port.
module resp_delay_line
    import mem_resp_pkg::*;
#(
    parameter int unsigned STAGES = 3
) (
    input  logic     clk,
    input  logic     rst,
    input  rsp_rec_t in_i,
    output rsp_rec_t out_o,
    output logic     busy_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign out_o  = in_i;
            assign busy_o = 1'b0;
        end else begin : g_pipe
            rsp_rec_t stage_q [STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(STAGES); i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= in_i;
                    for (int i = 1; i < int'(STAGES); i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            always_comb begin
                busy_o = 1'b0;
                for (int i = 0; i < int'(STAGES); i++) begin
                    busy_o = busy_o | stage_q[i].valid;
                end
            end

            assign out_o = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Memory target for MEM-stage and cache-fill traffic: single reads/writes and
// 4-beat read bursts, with in-order read data after a fixed latency.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic              req_burst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [BEAT_W-1:0] rsp_beat,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic              accept;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic [BEAT_W-1:0] issue_beat;
    logic [IDX_W-1:0]  issue_idx;
    logic [IDX_W-1:0]  wr_idx;
    rsp_rec_t          issue_d, issue_q, rsp_rec;
    logic              dl_busy;

    // State register plus the issue stage that feeds the delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            issue_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            issue_q <= issue_d;
        end
    end

    // Next-state logic: a burst read parks the FSM in BURST for beats 1..3.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !req_wr && req_burst) begin
                    state_d = BURST;
                    beat_d  = BEAT_W'(1);
                    base_d  = req_addr & BURST_ALIGN_MASK;
                end
            end
            BURST: begin
                beat_d = BEAT_W'(beat_q + 1'b1);
                if (beat_q == BEAT_W'(BURST_BEATS - 1)) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
    end

    // Output logic: handshake and issue mux between external request and burst beats.
    always_comb begin
        req_ready  = 1'b0;
        accept     = 1'b0;
        issue      = 1'b0;
        issue_addr = word_addr(req_addr);
        issue_beat = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = !rst;
                accept    = req_valid && !rst;
                issue     = accept && !req_wr;
                if (req_burst && !req_wr) begin
                    issue_addr = req_addr & BURST_ALIGN_MASK;
                end
            end
            BURST: begin
                issue      = 1'b1;
                issue_addr = base_q + ADDR_W'({beat_q, 1'b0});
                issue_beat = beat_q;
            end
            default: ;
        endcase
    end

    assign issue_idx = issue_addr[IDX_W:1];
    assign wr_idx    = req_addr[IDX_W:1];

    always_comb begin
        issue_d       = '0;
        issue_d.valid = issue;
        issue_d.beat  = issue_beat;
        issue_d.addr  = issue_addr;
        issue_d.data  = mem_q[issue_idx];
    end

    // Array is deliberately left out of reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (accept && req_wr) begin
            mem_q[wr_idx] <= req_wdata;
        end
    end

    resp_delay_line #(
        .STAGES (LATENCY - 1)
    ) u_delay_line (
        .clk    (clk),
        .rst    (rst),
        .in_i   (issue_q),
        .out_o  (rsp_rec),
        .busy_o (dl_busy)
    );

    assign rsp_valid = rsp_rec.valid;
    assign rsp_rdata = rsp_rec.data;
    assign rsp_addr  = rsp_rec.addr;
    assign rsp_beat  = rsp_rec.beat;
    assign busy      = issue_q.valid || dl_busy || (state_q == BURST);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed requests push expected read
// responses; a monitor pops and checks them as the DUT presents them.
module tb_mem_responder;

    localparam int unsigned LAT   = 4;
    localparam int unsigned WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wr, req_burst;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, busy;
    logic [15:0] rsp_rdata, rsp_addr;
    logic [1:0]  rsp_beat;

    mem_responder #(.MEM_WORDS(WORDS), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_burst (req_burst),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_addr  (rsp_addr),
        .rsp_beat  (rsp_beat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [15:0] addr;
        logic [1:0]  beat;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   rsp_seen = 0;
    int   acc_cyc = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && rsp_valid) begin
            exp_t e;
            rsp_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                chk("rsp_addr",  32'(rsp_addr),  32'(e.addr));
                chk("rsp_beat",  32'(rsp_beat),  32'(e.beat));
                chk("rsp_cycle", 32'(cyc),       32'(e.due));
            end
        end
    end

    // Present one request and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic wr, input logic burst, input logic [15:0] addr,
                        input logic [15:0] wdata);
        int waits = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_burst = burst;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
    endtask

    task automatic expect_rsp(input logic [15:0] data, input logic [15:0] addr,
                              input logic [1:0] beat, input int issue_cyc);
        exp_t e;
        e.data = data;
        e.addr = addr;
        e.beat = beat;
        e.due  = issue_cyc + int'(LAT) - 1;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base_cyc;
        int seen0;
        logic [15:0] bdat [4];

        rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_burst = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 chk("ready_in_reset", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset_rsp_addr",  32'(rsp_addr),  32'd0);
        chk("reset_rsp_beat",  32'(rsp_beat),  32'd0);
        chk("reset_busy",      32'(busy),      32'd0);

        // Single write then read, latency LAT.
        send(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        send(1'b0, 1'b0, 16'h0010, 16'h0000);
        expect_rsp(16'hBEEF, 16'h0010, 2'd0, acc_cyc);
        wait_drain();

        // Burst at unaligned 0x0023 reads aligned line 0x0020..0x0026.
        send(1'b1, 1'b0, 16'h0020, 16'h1111);
        send(1'b1, 1'b0, 16'h0022, 16'h2222);
        send(1'b1, 1'b0, 16'h0024, 16'h3333);
        send(1'b1, 1'b0, 16'h0026, 16'h4444);
        send(1'b0, 1'b1, 16'h0023, 16'h0000);
        bdat[0] = 16'h1111; bdat[1] = 16'h2222; bdat[2] = 16'h3333; bdat[3] = 16'h4444;
        for (int k = 0; k < 4; k++)
            expect_rsp(bdat[k], 16'h0020 + 16'(2 * k), 2'(k), acc_cyc + k);
        repeat (3) begin
            @(negedge clk);
            chk("burst_ready_low", 32'(req_ready), 32'd0);
            chk("burst_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("burst_ready_back", 32'(req_ready), 32'd1);
        wait_drain();

        // Back-to-back reads, busy held from first accept to last response.
        send(1'b1, 1'b0, 16'h0000, 16'h0A00);
        send(1'b1, 1'b0, 16'h0002, 16'h0A02);
        send(1'b1, 1'b0, 16'h0004, 16'h0A04);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        send(1'b0, 1'b0, 16'h0000, 16'h0000);
        expect_rsp(16'h0A00, 16'h0000, 2'd0, acc_cyc);
        chk("b2b_busy_first", 32'(busy), 32'd1);
        send(1'b0, 1'b0, 16'h0002, 16'h0000);
        expect_rsp(16'h0A02, 16'h0002, 2'd0, acc_cyc);
        send(1'b0, 1'b0, 16'h0004, 16'h0000);
        expect_rsp(16'h0A04, 16'h0004, 2'd0, acc_cyc);
        repeat (4) begin
            @(negedge clk);
            chk("b2b_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("b2b_busy_done", 32'(busy), 32'd0);
        wait_drain();

        // Write then read same word on consecutive cycles; odd address ignored bit 0.
        send(1'b1, 1'b0, 16'h0008, 16'hAAAA);
        send(1'b0, 1'b0, 16'h0009, 16'h0000);
        expect_rsp(16'hAAAA, 16'h0008, 2'd0, acc_cyc);
        wait_drain();

        // Address wrap: byte 0x0800 aliases word 0.
        send(1'b1, 1'b0, 16'h0800, 16'h5A5A);
        send(1'b0, 1'b0, 16'h0000, 16'h0000);
        expect_rsp(16'h5A5A, 16'h0000, 2'd0, acc_cyc);
        wait_drain();

        // Burst near the top: 0x0FF8 line aliases words 0x3FC..0x3FF.
        send(1'b1, 1'b0, 16'h07F8, 16'hC000);
        send(1'b1, 1'b0, 16'h07FA, 16'hC001);
        send(1'b1, 1'b0, 16'h07FC, 16'hC002);
        send(1'b1, 1'b0, 16'h07FE, 16'hC003);
        send(1'b0, 1'b1, 16'h0FFA, 16'h0000);
        for (int k = 0; k < 4; k++)
            expect_rsp(16'hC000 + 16'(k), 16'h0FF8 + 16'(2 * k), 2'(k), acc_cyc + k);
        wait_drain();

        // Reset two cycles into a burst drops every in-flight beat.
        seen0 = rsp_seen;
        send(1'b0, 1'b1, 16'h0030, 16'h0000);
        base_cyc = acc_cyc;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_edge_cycle", 32'(cyc), 32'(base_cyc + 2));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        chk("post_rst_no_rsp", 32'(rsp_seen - seen0), 32'd0);

        // Array contents survive reset.
        send(1'b0, 1'b0, 16'h0010, 16'h0000);
        expect_rsp(16'hBEEF, 16'h0010, 2'd0, acc_cyc);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
